modexp_scheduler: RTL and testbench
===================================

# modexp_scheduler

Sequencing controller for the fault-protected modular-exponentiation datapath. It walks the exponent LSB-first, issues the square-and-multiply command stream to the shared modular-multiply/reduce unit over a valid/ready command port, and runs the full main pass followed by a truncated recomputation pass. It checks the recomputation pass against the main pass using a checkpoint accumulator snapshot and the exponent Hamming weight, then raises `fault_flag`. It sits between the top-level input loader/encoder and the multiply/Barrett datapath.

## Interface
- `EXP_W`, 512: exponent width in bits.
- `OP_W`, 512: accumulator width in bits.
- `CHK_IDX`, 50: checkpoint bit index; must satisfy 0 ≤ CHK_IDX < EXP_W.
- `WT_W`, 10: weight counter width; equals clog2(EXP_W+1).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-low (0 = reset).
- `start` in 1: one-cycle pulse that begins an exponentiation; ignored while `busy`.
- `exp_1` in EXP_W: reduced exponent for pass 1; sampled on `start`.
- `exp_2` in EXP_W: reduced exponent for pass 2; sampled on `start`.
- `cmd_valid` out 1: command valid.
- `cmd_ready` in 1: datapath accepts the command.
- `cmd_op` out 2: command opcode. 00 = INIT (acc←1, base←encoded x of `cmd_pass`), 01 = MUL (acc←acc·base mod N), 10 = SQR (base←base² mod N).
- `cmd_pass` out 1: 0 = main pass, 1 = recomputation pass.
- `rsp_valid` in 1: one-cycle pulse when the accepted command completes.
- `rsp_acc` in OP_W: datapath accumulator value; valid with `rsp_valid`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the verdict is valid.
- `result` out OP_W: final accumulator from pass 1; held until the next `start`.
- `fault_flag` out 1: 1 = fault detected; held until the next `start`.

## Operation
- States: IDLE, ISSUE, WAIT, NEXT, COUNT, CMP.
- IDLE, on `start`:
  - latch `exp_1` and `exp_2`;
  - clear `pass`, bit index k, `wt_1`, `wt_2`, `snap_1`, `snap_2`, `fault_flag`;
  - load the pending op INIT and go to ISSUE.
- ISSUE: drive `cmd_valid`=1 with `cmd_op`/`cmd_pass` held stable. On `cmd_valid & cmd_ready`, go to WAIT.
- WAIT: on `rsp_valid`, choose the next op:
  - after INIT: MUL if e[k]=1, otherwise SQR;
  - after MUL: SQR;
  - after SQR: go to NEXT.
  - e is the latched exponent of the current pass.
- NEXT, which handles bit k:
  - `wt_pass` += e[k].
  - If k==CHK_IDX, `snap_pass` ← the `rsp_acc` captured on that SQR response.
  - Pass 0, k==EXP_W−1: `result` ← captured `rsp_acc`, then pass←1, k←0, pending INIT, go to ISSUE.
  - Pass 1, k==CHK_IDX: k←k+1, go to COUNT. No further commands are issued.
  - Otherwise: k←k+1, go to ISSUE with MUL if the new e[k]=1, otherwise SQR.
- COUNT: one bit per cycle, `wt_2` += exp_2[k], k←k+1. Leave after bit EXP_W−1 is added. If CHK_IDX==EXP_W−1, COUNT is skipped.
- CMP: `fault_flag` ← (`snap_1`≠`snap_2`) | (`wt_1`≠`wt_2`). Pulse `done`, return to IDLE.
- Weights saturate-free: WT_W always holds EXP_W.
- Command count: pass 0 issues 1+popcount(exp_1)+EXP_W commands; pass 1 issues 1+popcount(exp_2[CHK_IDX:0])+CHK_IDX+1 commands.

## Timing
- Reset values (`rst`=0 at an edge): state IDLE; `cmd_valid`, `busy`, `done`, `fault_flag` = 0; `cmd_op`=00; `cmd_pass`=0; `result`=0; all counters and snapshots 0.
- Reset mid-operation aborts immediately. An outstanding datapath response is then ignored because the state is IDLE.
- `start`→`cmd_valid`: 1 cycle.
- `cmd_valid` holds until accepted. At most one command is outstanding.
- `rsp_valid` outside WAIT is ignored. `rsp_valid` arriving in the same cycle as acceptance is ignored; a response counts only in WAIT.
- `cmd_valid` is deasserted in WAIT, NEXT, COUNT and CMP.
- With immediate ready and 1-cycle response, each command costs 3 cycles (ISSUE, WAIT, response) and each bit adds 1 NEXT cycle.
- COUNT takes EXP_W−1−CHK_IDX cycles. CMP takes 1 cycle; `done` is asserted there.
- `start` while `busy` has no effect. `start` in the same cycle as `done` is ignored.

## Test plan
- EXP_W=8, CHK_IDX=3, exp_1=exp_2=8'hB5, ideal datapath model → op stream INIT,MUL,SQR,SQR,MUL,SQR,SQR,MUL,SQR,MUL,SQR,SQR,MUL,SQR (14 commands), then pass 1 with 7 commands; `fault_flag`=0; `result` = model x^0xB5 mod N.
- Same setup, but the model corrupts `rsp_acc` once during pass 1 bit 2 → `fault_flag`=1, `done` pulses once.
- exp_1=8'hB5, exp_2=8'hB4 (weights 5 vs 4, differing at bit 0) → `fault_flag`=1.
- exp_2=8'hF5 (differs above CHK_IDX only) → snapshots match, weights 5 vs 6, `fault_flag`=1, pass 1 still stops after 7 commands.
- `cmd_ready` held low 5 cycles on every command, plus a spurious `rsp_valid` in ISSUE → `cmd_op` stays stable while stalled, the spurious pulse is ignored, and the final verdict matches the first scenario.
- `rst`=0 in pass 0 at k=4, then a new `start` → all outputs return to 0 in 1 cycle, and the rerun completes identically to the first scenario.

Source files
------------

// File: rtl/modexp_scheduler.sv
// Square-and-multiply command sequencer with a truncated recomputation pass.
// The recomputation pass is compared against the main pass by checkpoint snapshot and exponent weight.
module modexp_scheduler #(
    parameter int EXP_W   = 512,
    parameter int OP_W    = 512,
    parameter int CHK_IDX = 50,
    parameter int WT_W    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [EXP_W-1:0] exp_1,
    input  logic [EXP_W-1:0] exp_2,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [1:0]       cmd_op,
    output logic             cmd_pass,
    input  logic             rsp_valid,
    input  logic [OP_W-1:0]  rsp_acc,
    output logic             busy,
    output logic             done,
    output logic [OP_W-1:0]  result,
    output logic             fault_flag,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_COUNT = 3'd4,
        S_CMP   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT = 2'b00,
        OP_MUL  = 2'b01,
        OP_SQR  = 2'b10
    } op_t;

    localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
    localparam logic [WT_W-1:0] CHK_K  = WT_W'(CHK_IDX);
    localparam logic [WT_W-1:0] LAST_K = WT_W'(EXP_W - 1);

    state_t           state_q, state_d;
    op_t              op_q, op_d;
    logic             pass_q, pass_d;
    logic [WT_W-1:0]  k_q, k_d;
    logic [WT_W-1:0]  wt1_q, wt1_d, wt2_q, wt2_d;
    logic [OP_W-1:0]  snap1_q, snap1_d, snap2_q, snap2_d;
    logic [OP_W-1:0]  acc_q, acc_d;
    logic [OP_W-1:0]  result_q, result_d;
    logic [EXP_W-1:0] e1_q, e1_d, e2_q, e2_d;
    logic             fault_q, fault_d;

    logic [EXP_W-1:0] e_cur;
    logic [WT_W-1:0]  k_inc;
    logic [WT_W-1:0]  bit_w;
    logic             bit_k, bit_next, verdict;

    assign e_cur    = pass_q ? e2_q : e1_q;
    assign k_inc    = k_q + 1'b1;
    // bit_next is only consumed when k_inc still addresses a valid bit
    assign bit_k    = e_cur[k_q[IDX_W-1:0]];
    assign bit_next = e_cur[k_inc[IDX_W-1:0]];
    assign bit_w    = {{(WT_W-1){1'b0}}, bit_k};
    assign verdict  = (snap1_q != snap2_q) || (wt1_q != wt2_q);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        pass_d   = pass_q;
        k_d      = k_q;
        wt1_d    = wt1_q;
        wt2_d    = wt2_q;
        snap1_d  = snap1_q;
        snap2_d  = snap2_q;
        acc_d    = acc_q;
        result_d = result_q;
        e1_d     = e1_q;
        e2_d     = e2_q;
        fault_d  = fault_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    e1_d    = exp_1;
                    e2_d    = exp_2;
                    pass_d  = 1'b0;
                    k_d     = '0;
                    wt1_d   = '0;
                    wt2_d   = '0;
                    snap1_d = '0;
                    snap2_d = '0;
                    fault_d = 1'b0;
                    op_d    = OP_INIT;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (rsp_valid) begin
                    unique case (op_q)
                        OP_INIT: begin
                            op_d    = bit_k ? OP_MUL : OP_SQR;
                            state_d = S_ISSUE;
                        end
                        OP_MUL: begin
                            op_d    = OP_SQR;
                            state_d = S_ISSUE;
                        end
                        default: begin
                            acc_d   = rsp_acc;
                            state_d = S_NEXT;
                        end
                    endcase
                end
            end
            S_NEXT: begin
                if (pass_q) wt2_d = wt2_q + bit_w;
                else        wt1_d = wt1_q + bit_w;
                if (k_q == CHK_K) begin
                    if (pass_q) snap2_d = acc_q;
                    else        snap1_d = acc_q;
                end
                if (!pass_q && (k_q == LAST_K)) begin
                    result_d = acc_q;
                    pass_d   = 1'b1;
                    k_d      = '0;
                    op_d     = OP_INIT;
                    state_d  = S_ISSUE;
                end else if (pass_q && (k_q == CHK_K)) begin
                    // Bits above the checkpoint only contribute to the pass-2 weight
                    k_d     = k_inc;
                    state_d = (CHK_K == LAST_K) ? S_CMP : S_COUNT;
                end else begin
                    k_d     = k_inc;
                    op_d    = bit_next ? OP_MUL : OP_SQR;
                    state_d = S_ISSUE;
                end
            end
            S_COUNT: begin
                wt2_d = wt2_q + bit_w;
                k_d   = k_inc;
                if (k_q == LAST_K) state_d = S_CMP;
            end
            S_CMP: begin
                fault_d = verdict;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= OP_INIT;
            pass_q   <= 1'b0;
            k_q      <= '0;
            wt1_q    <= '0;
            wt2_q    <= '0;
            snap1_q  <= '0;
            snap2_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            e1_q     <= '0;
            e2_q     <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            pass_q   <= pass_d;
            k_q      <= k_d;
            wt1_q    <= wt1_d;
            wt2_q    <= wt2_d;
            snap1_q  <= snap1_d;
            snap2_q  <= snap2_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            e1_q     <= e1_d;
            e2_q     <= e2_d;
            fault_q  <= fault_d;
        end
    end

    // The verdict is shown combinationally in CMP so it is valid alongside done
    assign cmd_valid  = (state_q == S_ISSUE);
    assign cmd_op     = op_q;
    assign cmd_pass   = pass_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_CMP);
    assign result     = result_q;
    assign fault_flag = (state_q == S_CMP) ? verdict : fault_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_modexp_scheduler.sv
// Bench for modexp_scheduler: ideal modular datapath responder plus a scoreboard
// of expected command streams and verdicts derived from x^e mod N arithmetic.
module tb_modexp_scheduler;

    localparam int EXP_W   = 8;
    localparam int OP_W    = 16;
    localparam int CHK_IDX = 3;
    localparam int WT_W    = 4;
    localparam longint unsigned N = 65521;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [EXP_W-1:0] exp_1 = '0;
    logic [EXP_W-1:0] exp_2 = '0;
    logic             cmd_ready = 1'b0;
    logic             rsp_valid = 1'b0;
    logic [OP_W-1:0]  rsp_acc = '0;
    logic             cmd_valid, cmd_pass, busy, done, fault_flag;
    logic [1:0]       cmd_op;
    logic [OP_W-1:0]  result;
    logic [2:0]       dbg_state;

    modexp_scheduler #(
        .EXP_W(EXP_W), .OP_W(OP_W), .CHK_IDX(CHK_IDX), .WT_W(WT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .exp_1(exp_1), .exp_2(exp_2),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_pass(cmd_pass),
        .rsp_valid(rsp_valid), .rsp_acc(rsp_acc), .busy(busy), .done(done),
        .result(result), .fault_flag(fault_flag), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [2:0]      exp_q[$];      // expected {pass, op} per accepted command
    logic [OP_W:0]   exp_res_q[$];  // expected {fault_flag, result} per done

    // datapath model state
    logic [OP_W-1:0]  x_val = 16'd3;
    bit               stall_mode = 0, corrupt_mode = 0, rand_mode = 0, corrupted = 0;
    bit               pending = 0;
    int               lat_cnt = 0, wcnt = 0, p0_sqr = 0, p1_sqr = 0;
    longint unsigned  m_acc = 1, m_base = 1;
    logic [OP_W-1:0]  pend_val = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic longint unsigned mpow(input longint unsigned x, input int e);
        longint unsigned r = 1;
        for (int i = 0; i < e; i++) r = (r * x) % N;
        return r;
    endfunction

    function automatic int popc(input logic [EXP_W-1:0] v);
        int c = 0;
        for (int i = 0; i < EXP_W; i++) c += int'(v[i]);
        return c;
    endfunction

    function automatic void push_pass(input logic p, input logic [EXP_W-1:0] e, input int nbits);
        exp_q.push_back({p, 2'b00});
        for (int i = 0; i < nbits; i++) begin
            if (e[i]) exp_q.push_back({p, 2'b01});
            exp_q.push_back({p, 2'b10});
        end
    endfunction

    // Datapath responder: decides ready just after each edge, answers after a latency.
    initial begin
        forever begin
            @(posedge clk); #1;
            rsp_valid = 1'b0;
            if (!rst) begin
                cmd_ready = 1'b0;
                pending = 0;
                wcnt = 0;
            end else begin
                if (pending) begin
                    if (lat_cnt == 0) begin
                        rsp_valid = 1'b1;
                        rsp_acc = pend_val;
                        pending = 0;
                    end else lat_cnt--;
                end
                if (cmd_valid && !pending) begin
                    bit r;
                    if (stall_mode) begin
                        wcnt++;
                        r = (wcnt > 5);
                        if (wcnt == 3) begin
                            rsp_valid = 1'b1;
                            rsp_acc = OP_W'($urandom);
                        end
                    end else if (rand_mode) r = 1'($urandom_range(0, 1));
                    else r = 1;
                    cmd_ready = r;
                    if (r) begin
                        wcnt = 0;
                        case (cmd_op)
                            2'b00: begin m_acc = 1; m_base = longint'(x_val); end
                            2'b01: m_acc = (m_acc * m_base) % N;
                            2'b10: begin
                                m_base = (m_base * m_base) % N;
                                if (cmd_pass) begin
                                    if (corrupt_mode && p1_sqr == 2 && !corrupted) begin
                                        m_acc = (m_acc + 1) % N;
                                        corrupted = 1;
                                    end
                                    p1_sqr++;
                                end else p0_sqr++;
                            end
                            default: ;
                        endcase
                        pend_val = OP_W'(m_acc);
                        pending = 1;
                        lat_cnt = rand_mode ? $urandom_range(0, 3) : 0;
                    end
                end else cmd_ready = 1'b0;
            end
        end
    end

    // Monitor: pops expectations on every accepted command and every done pulse.
    initial begin
        bit prev_stall = 0;
        logic [2:0] prev_cmd = '0;
        forever begin
            @(negedge clk);
            if (!rst) prev_stall = 0;
            else begin
                if (cmd_valid && prev_stall) check("op_stable", {cmd_pass, cmd_op}, prev_cmd);
                prev_stall = cmd_valid && !cmd_ready;
                prev_cmd = {cmd_pass, cmd_op};
                if (cmd_valid && cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_cmd: got op %0d pass %0d expected none", cmd_op, cmd_pass);
                    end else check("cmd", {cmd_pass, cmd_op}, exp_q.pop_front());
                end
                if (done) begin
                    done_cnt++;
                    if (exp_res_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL extra_done: got done expected none");
                    end else begin
                        logic [OP_W:0] er;
                        er = exp_res_q.pop_front();
                        check("result", result, er[OP_W-1:0]);
                        check("fault_flag", fault_flag, er[OP_W]);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic launch(input logic [EXP_W-1:0] e1, input logic [EXP_W-1:0] e2,
                          input logic [OP_W-1:0] x, input bit stall, input bit corrupt, input bit rmode);
        logic [EXP_W-1:0] mask;
        bit f;
        mask = EXP_W'((1 << (CHK_IDX + 1)) - 1);
        x_val = x; stall_mode = stall; corrupt_mode = corrupt; rand_mode = rmode;
        corrupted = 0; p0_sqr = 0; p1_sqr = 0;
        push_pass(1'b0, e1, EXP_W);
        push_pass(1'b1, e2, CHK_IDX + 1);
        f = corrupt || (popc(e1) != popc(e2)) ||
            (mpow(longint'(x), int'(e1 & mask)) != mpow(longint'(x), int'(e2 & mask)));
        exp_res_q.push_back({f, OP_W'(mpow(longint'(x), int'(e1)))});
        exp_1 = e1; exp_2 = e2; start = 1'b1;
        tick();
        start = 1'b0;
        exp_1 = EXP_W'($urandom); exp_2 = EXP_W'($urandom);
        @(negedge clk);
        check("start_busy", busy, 1'b1);
        check("start_cmd_valid", cmd_valid, 1'b1);
    endtask

    task automatic run_case(input logic [EXP_W-1:0] e1, input logic [EXP_W-1:0] e2,
                            input logic [OP_W-1:0] x, input bit stall, input bit corrupt,
                            input bit rmode, input bit busy_start, input bit done_start);
        int d0, c;
        logic [OP_W:0] er;
        d0 = done_cnt;
        launch(e1, e2, x, stall, corrupt, rmode);
        er = exp_res_q[exp_res_q.size() - 1];
        if (busy_start) begin
            repeat (7) @(negedge clk);
            exp_1 = ~e1; exp_2 = ~e2; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        c = 0;
        while (!done && c < 3000) begin @(negedge clk); c++; end
        if (c >= 3000) begin
            checks++; failures++;
            $display("FAIL done_timeout: got no done expected done within 3000 cycles");
        end else if (done_start) begin
            exp_1 = 8'h0F; exp_2 = 8'h0F; start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
            @(negedge clk);
            check("start_at_done_busy", busy, 1'b0);
            check("start_at_done_cmd_valid", cmd_valid, 1'b0);
        end
        repeat (3) tick();
        check("done_once", done_cnt - d0, 1);
        check("cmd_queue_drained", exp_q.size(), 0);
        check("result_held", result, er[OP_W-1:0]);
        check("fault_held", fault_flag, er[OP_W]);
    endtask

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [OP_W-1:0] x0;
        int c;
        x0 = OP_W'($urandom_range(2, 65519));
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_cmd_valid", cmd_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_fault", fault_flag, 1'b0);
        check("rst_result", result, '0);
        check("rst_state", dbg_state, 3'd0);
        tick();
        rst = 1'b1;
        tick();

        run_case(8'hB5, 8'hB5, x0, 0, 0, 0, 0, 0);
        run_case(8'hB5, 8'hB5, x0, 0, 1, 0, 0, 0);
        run_case(8'hB5, 8'hB4, x0, 0, 0, 0, 0, 0);
        run_case(8'hB5, 8'hF5, x0, 0, 0, 0, 0, 0);
        run_case(8'hB5, 8'hB5, x0, 1, 0, 0, 0, 0);

        // abort in pass 0 around bit 4, then rerun the reference case
        launch(8'hB5, 8'hB5, x0, 0, 0, 0);
        c = 0;
        while (p0_sqr < 4 && c < 500) begin tick(); c++; end
        check("abort_reached_bit4", p0_sqr >= 4, 1'b1);
        tick();
        rst = 1'b0; cmd_ready = 1'b0; rsp_valid = 1'b0; pending = 0;
        exp_q.delete(); exp_res_q.delete();
        tick();
        @(negedge clk);
        check("abort_cmd_valid", cmd_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        check("abort_fault", fault_flag, 1'b0);
        check("abort_result", result, '0);
        check("abort_cmd_op", cmd_op, 2'b00);
        check("abort_cmd_pass", cmd_pass, 1'b0);
        rst = 1'b1;
        tick();
        run_case(8'hB5, 8'hB5, x0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            logic [EXP_W-1:0] a, b;
            a = EXP_W'($urandom);
            b = ($urandom_range(0, 1) == 1) ? a : EXP_W'($urandom);
            run_case(a, b, OP_W'($urandom_range(2, 65519)), 0, 0, 1, i == 1, i == 3);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
